// File: rtl/dense_weight_update_if.sv
// Handshake and data bundle for dense_weight_update: input bundle in, updated weights out.
interface dense_weight_update_if #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int learning_rate_size     = 16,
    parameter int backprop_controll_size = 66
);
    logic                              in_valid;
    logic                              in_ready;
    logic [data_size*size-1:0]         x;
    logic [data_size*size-1:0]         w;
    logic [data_size-1:0]              delta;
    logic [learning_rate_size-1:0]     learning_rate;
    logic [backprop_controll_size-1:0] backprop_controll;
    logic                              out_valid;
    logic                              out_ready;
    logic [data_size*size-1:0]         w_new;
    logic [backprop_controll_size-1:0] backprop_controll_out;

    modport master (
        output in_valid, x, w, delta, learning_rate, backprop_controll, out_ready,
        input  in_ready, out_valid, w_new, backprop_controll_out
    );

    modport slave (
        input  in_valid, x, w, delta, learning_rate, backprop_controll, out_ready,
        output in_ready, out_valid, w_new, backprop_controll_out
    );
endinterface

// File: rtl/dense_weight_update.sv
// Serial weight update w_new[i] = w[i] - (lr*delta)*x[i], one element per cycle.
// Define DENSE_WEIGHT_UPDATE_SAT_EN to saturate every data_size reduction instead of wrapping.
module dense_weight_update #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int frac_bits              = 8,
    parameter int learning_rate_size     = 16,
    parameter int backprop_controll_size = 66
) (
    input logic                 clk,
    input logic                 reset,
    dense_weight_update_if.slave bus
);
    localparam int PW = 2 * data_size;
    localparam int IW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {IDLE, SCALE, CALC, DONE} state_t;

    state_t                            r_state;
    logic [IW-1:0]                     r_idx;
    logic [data_size*size-1:0]         r_x;
    logic [data_size*size-1:0]         r_w;
    logic [data_size-1:0]              r_delta;
    logic [learning_rate_size-1:0]     r_lr;
    logic [data_size-1:0]              r_scale;
    logic                              r_in_ready;
    logic                              r_out_valid;
    logic [data_size*size-1:0]         r_w_new;
    logic [backprop_controll_size-1:0] r_bc_out;

    logic [data_size-1:0]              w_x_sel;
    logic [data_size-1:0]              w_w_sel;

    // Reduce a PW+1 bit signed value to data_size bits.
    function automatic logic [data_size-1:0] f_reduce(input logic signed [PW:0] v);
        logic [data_size-1:0] res;
`ifdef DENSE_WEIGHT_UPDATE_SAT_EN
        logic [PW-data_size+1:0] hi;
        hi = v[PW:data_size-1];
        if ((&hi) || !(|hi))
            res = v[data_size-1:0];
        else if (v[PW])
            res = {1'b1, {(data_size-1){1'b0}}};
        else
            res = {1'b0, {(data_size-1){1'b1}}};
`else
        res = v[data_size-1:0];
`endif
        return res;
    endfunction

    function automatic logic [data_size-1:0] f_scale(
        input logic [learning_rate_size-1:0] lr,
        input logic [data_size-1:0]          d
    );
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sh;
        prod = $signed(lr) * $signed(d);
        sh   = prod >>> frac_bits;
        return f_reduce($signed({sh[PW-1], sh}));
    endfunction

    function automatic logic [data_size-1:0] f_update(
        input logic [data_size-1:0] s,
        input logic [data_size-1:0] xv,
        input logic [data_size-1:0] wv
    );
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] p;
        logic signed [PW:0]   d;
        prod = $signed(s) * $signed(xv);
        p    = prod >>> frac_bits;
        d    = $signed({{(PW+1-data_size){wv[data_size-1]}}, wv}) - $signed({p[PW-1], p});
        return f_reduce(d);
    endfunction

    always_comb begin
        w_x_sel = r_x[r_idx*data_size +: data_size];
        w_w_sel = r_w[r_idx*data_size +: data_size];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_x         <= '0;
            r_w         <= '0;
            r_delta     <= '0;
            r_lr        <= '0;
            r_scale     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_new     <= '0;
            r_bc_out    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_ready && bus.in_valid) begin
                        r_x        <= bus.x;
                        r_w        <= bus.w;
                        r_delta    <= bus.delta;
                        r_lr       <= bus.learning_rate;
                        r_bc_out   <= bus.backprop_controll;
                        r_in_ready <= 1'b0;
                        r_state    <= SCALE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                SCALE: begin
                    r_scale <= f_scale(r_lr, r_delta);
                    r_idx   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_w_new[r_idx*data_size +: data_size] <= f_update(r_scale, w_x_sel, w_w_sel);
                    if (r_idx == IW'(size - 1)) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready is raised on the same edge so the next bundle can land one cycle later.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready              = r_in_ready;
    assign bus.out_valid             = r_out_valid;
    assign bus.w_new                 = r_w_new;
    assign bus.backprop_controll_out = r_bc_out;
endmodule
